pattern_loader: RTL and testbench
=================================

PATTERN_LOADER -- requirements
Module: pattern_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 32, number of pattern words loaded per pass (4 levels x 8 patterns).
REQ-002 SHALL have parameter WIDTH, default 9, pattern word width (one bit per board cell, bit 8 = top-left).
REQ-003 SHALL have parameter READ_LAT, default 2, pattern RAM read latency in clocks.
REQ-004 SHALL have ports: clock in 1 system clock; reset in 1 asynchronous active-low reset.
REQ-005 SHALL have ports: start in 1 one-cycle load request; pat_in in WIDTH incoming pattern; pat_valid in 1 pat_in valid; pat_ready out 1 loader accepts word.
REQ-006 SHALL have ports: ram_address out 5 RAM address; ram_data out WIDTH write data; ram_wren out 1 write strobe; ram_q in WIDTH RAM read data.
REQ-007 SHALL have ports: busy out 1; done out 1; error out 1; err_addr out 5 first failing address; checksum out WIDTH XOR of written words; HEX0 out 7 state digit.

Function
REQ-008 SHALL implement states IDLE(0), WAIT(1), WRITE(2), VERIFY(3), DONE(4); HEX0 shows the state code.
REQ-009 IDLE: start=1 -> WAIT next cycle; wr_addr, checksum, error, err_addr cleared; done cleared.
REQ-010 WAIT: pat_ready=1; transfer occurs only on a clock edge with pat_valid=1 and pat_ready=1; word captured, -> WRITE.
REQ-011 WRITE: exactly one cycle with ram_wren=1, ram_address=wr_addr, ram_data=captured word; checksum ^= word; pat_ready=0.
REQ-012 After WRITE: if wr_addr=DEPTH-1 -> VERIFY (or DONE, see REQ-020), wr_addr wraps to 0; else wr_addr+1, -> WAIT.
REQ-013 Maximum throughput one word per 2 clocks; pat_valid held while pat_ready=0 SHALL NOT be consumed twice.
REQ-014 VERIFY: issues addresses 0..DEPTH-1 one per clock, ram_wren=0; compares ram_q READ_LAT cycles after each address with stored word.
REQ-015 Loader SHALL keep a DEPTH x WIDTH shadow copy for comparison; checksum SHALL be WIDTH-bit XOR, no carry.
REQ-016 First mismatch sets error=1 and err_addr=address; later mismatches SHALL NOT change err_addr; verify continues to the end.
REQ-017 VERIFY -> DONE after last compare; DONE: done=1, busy=0; start=1 in DONE restarts as from IDLE.
REQ-018 busy=1 in WAIT, WRITE, VERIFY; start while busy SHALL be ignored.
REQ-019 ram_wren SHALL be 0 in every state except WRITE; ram_address=0 when idle.

Reset
REQ-020 reset=0 SHALL asynchronously force IDLE, pat_ready=0, ram_wren=0, ram_address=0, ram_data=0, busy=0, done=0, error=0, err_addr=0, checksum=0; mid-load reset abandons the pass, partial RAM contents undefined.

Configuration
REQ-021 With LOADER_VERIFY_EN defined: VERIFY state, shadow copy and error/err_addr logic present.
REQ-022 Without LOADER_VERIFY_EN: WRITE of last word -> DONE directly; no shadow copy; error and err_addr tied 0; ram_q unused.

Structure
REQ-023 Shared package pattern_pkg SHALL hold DEPTH, WIDTH, READ_LAT defaults and the state encoding constants.
REQ-024 One sub-module, hexDecoder, SHALL drive HEX0 from {1'b0, state}.

Verification
REQ-025 Reset mid-WRITE at word 5 -> all outputs at REQ-020 values within same cycle, state IDLE, HEX0 shows 0.
REQ-026 start, stream words k*9'h015 (k=0..31) with pat_valid always 1 -> 32 wren pulses addr 0..31, one per 2 clocks, checksum = XOR of stream, done=1, error=0.
REQ-027 pat_valid toggled randomly with gaps up to 10 cycles -> exactly 32 writes, no duplicated or dropped words.
REQ-028 Verify build, RAM model corrupts addr 7 and 20 -> error=1, err_addr=7, done=1.
REQ-029 start pulsed during WAIT at word 3 -> ignored, load completes normally, wr_addr not reset.
REQ-030 Non-verify build, 32 words 9'h1FF -> DONE 1 cycle after last write, checksum=9'h000, error=0.

Source files
------------

// File: rtl/pattern_pkg.sv
// Shared defaults and FSM state encoding for the pattern loader.
// LOADER_VERIFY_EN (top) enables the read-back verify pass.
package pattern_pkg;
  localparam int DEF_DEPTH    = 32;
  localparam int DEF_WIDTH    = 9;
  localparam int DEF_READ_LAT = 2;
  localparam int AW           = 5;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_WRITE  = 3'd2,
    S_VERIFY = 3'd3,
    S_DONE   = 3'd4
  } state_t;
endpackage

// File: rtl/pattern_loader_hex.sv
// Seven-segment decoder, active-low segments ordered {g,f,e,d,c,b,a}.
module hexDecoder (
  input  logic [3:0] digit,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h7F;
    case (digit)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end
endmodule

// File: rtl/pattern_loader.sv
// Streams DEPTH pattern words into a RAM, one write per 2 clocks, with XOR checksum.
// Define LOADER_VERIFY_EN to add a read-back pass against a shadow copy.
module pattern_loader
  import pattern_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int READ_LAT = DEF_READ_LAT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pat_in,
  input  logic             pat_valid,
  output logic             pat_ready,
  output logic [AW-1:0]    ram_address,
  output logic [WIDTH-1:0] ram_data,
  output logic             ram_wren,
  input  logic [WIDTH-1:0] ram_q,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [AW-1:0]    err_addr,
  output logic [WIDTH-1:0] checksum,
  output logic [6:0]       HEX0
);
  localparam logic [AW-1:0] LAST = AW'(DEPTH-1);

  state_t        state;
  logic [AW-1:0] wr_addr;

`ifdef LOADER_VERIFY_EN
  logic [WIDTH-1:0]          shadow [DEPTH];
  logic                      issuing;
  logic                      issue;
  logic [READ_LAT:1]         vld_pipe;
  logic [READ_LAT:1][AW-1:0] addr_pipe;
  logic                      cmp_vld;
  logic [AW-1:0]             cmp_addr;
  logic                      cmp_bad;

  assign issue    = (state == S_VERIFY) && issuing;
  assign cmp_vld  = vld_pipe[READ_LAT];
  assign cmp_addr = addr_pipe[READ_LAT];
  assign cmp_bad  = cmp_vld && (ram_q != shadow[cmp_addr]);

  // ram_data still holds the captured word throughout WRITE
  always_ff @(posedge clock)
    if (state == S_WRITE) shadow[wr_addr] <= ram_data;

  // tracks each issued read address until its data returns on ram_q
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_pipe  <= '0;
      addr_pipe <= '0;
    end else begin
      vld_pipe[1]  <= issue;
      addr_pipe[1] <= ram_address;
      for (int k = 2; k <= READ_LAT; k++) begin
        vld_pipe[k]  <= vld_pipe[k-1];
        addr_pipe[k] <= addr_pipe[k-1];
      end
    end
  end
`else
  logic unused_q;
  localparam int unused_lat = READ_LAT;
  assign unused_q = ^ram_q;
  assign error    = 1'b0;
  assign err_addr = '0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      wr_addr     <= '0;
      pat_ready   <= 1'b0;
      ram_address <= '0;
      ram_data    <= '0;
      ram_wren    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      checksum    <= '0;
`ifdef LOADER_VERIFY_EN
      error       <= 1'b0;
      err_addr    <= '0;
      issuing     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_WAIT;
            wr_addr   <= '0;
            checksum  <= '0;
            done      <= 1'b0;
            busy      <= 1'b1;
            pat_ready <= 1'b1;
`ifdef LOADER_VERIFY_EN
            error     <= 1'b0;
            err_addr  <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (pat_valid && pat_ready) begin
            state       <= S_WRITE;
            pat_ready   <= 1'b0;
            ram_wren    <= 1'b1;
            ram_address <= wr_addr;
            ram_data    <= pat_in;
          end
        end
        S_WRITE: begin
          ram_wren    <= 1'b0;
          ram_address <= '0;
          checksum    <= checksum ^ ram_data;
          if (wr_addr == LAST) begin
            wr_addr <= '0;
`ifdef LOADER_VERIFY_EN
            state   <= S_VERIFY;
            issuing <= 1'b1;
`else
            state   <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
`endif
          end else begin
            wr_addr   <= wr_addr + 1'b1;
            state     <= S_WAIT;
            pat_ready <= 1'b1;
          end
        end
`ifdef LOADER_VERIFY_EN
        S_VERIFY: begin
          if (issuing) begin
            if (ram_address == LAST) begin
              issuing     <= 1'b0;
              ram_address <= '0;
            end else begin
              ram_address <= ram_address + 1'b1;
            end
          end
          if (cmp_bad && !error) begin
            error    <= 1'b1;
            err_addr <= cmp_addr;
          end
          if (cmp_vld && cmp_addr == LAST) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  hexDecoder u_hex (
    .digit ({1'b0, state}),
    .seg   (HEX0)
  );
endmodule

// File: tb/tb_pattern_loader.sv
// Self-checking bench for pattern_loader; verify-specific expectations follow LOADER_VERIFY_EN.
module tb_pattern_loader;
  localparam int DEPTH = 32, WIDTH = 9, READ_LAT = 2;
`ifdef LOADER_VERIFY_EN
  localparam int DONE_LAT = DEPTH + READ_LAT + 1;
  localparam bit VERIFY   = 1'b1;
`else
  localparam int DONE_LAT = 1;
  localparam bit VERIFY   = 1'b0;
`endif
  localparam logic [6:0] HEX_IDLE = 7'h40, HEX_WAIT = 7'h79, HEX_DONE = 7'h19;

  logic             clock = 1'b0, reset = 1'b1, start = 1'b0, pat_valid = 1'b0;
  logic [WIDTH-1:0] pat_in = '0;
  logic             pat_ready, ram_wren, busy, done, error;
  logic [4:0]       ram_address, err_addr;
  logic [WIDTH-1:0] ram_data, ram_q, checksum;
  logic [6:0]       HEX0;

  always #5 clock = ~clock;

  pattern_loader #(.DEPTH(DEPTH), .WIDTH(WIDTH), .READ_LAT(READ_LAT)) dut (
    .clock(clock), .reset(reset), .start(start), .pat_in(pat_in), .pat_valid(pat_valid),
    .pat_ready(pat_ready), .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q), .busy(busy), .done(done), .error(error), .err_addr(err_addr),
    .checksum(checksum), .HEX0(HEX0)
  );

  // RAM model with READ_LAT read pipeline; optional read corruption at addresses 7 and 20
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] qp  [READ_LAT];
  logic             corrupt = 1'b0;
  logic [WIDTH-1:0] rd;
  always_comb rd = mem[ram_address] ^
    ((corrupt && (ram_address == 5'd7 || ram_address == 5'd20)) ? 9'h001 : 9'h000);
  always @(posedge clock) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    qp[0] <= rd;
    for (int k = 1; k < READ_LAT; k++) qp[k] <= qp[k-1];
  end
  assign ram_q = qp[READ_LAT-1];

  int checks = 0, errors = 0;
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  // write monitor: every strobe must carry the next expected address/word
  logic [WIDTH-1:0] exp_words [DEPTH];
  int wr_count = 0, cyc = 0, last_wr_cyc = 0;
  logic prev_wren = 1'b0;
  always @(posedge clock) cyc++;
  always @(negedge clock) begin
    if (ram_wren) begin
      check("wren_back_to_back", int'(prev_wren), 0);
      check("write_overflow", int'(wr_count < DEPTH), 1);
      if (wr_count < DEPTH) begin
        check("wr_addr", ram_address, wr_count);
        check("wr_data", ram_data, exp_words[wr_count]);
      end
      wr_count++;
      last_wr_cyc = cyc;
    end
    prev_wren = ram_wren;
  end

  function automatic logic [WIDTH-1:0] stream_word(input int pat, input int k);
    logic [WIDTH-1:0] kk;
    kk = WIDTH'(k);
    case (pat)
      0:       return kk * 9'h015;
      1:       return 9'h1FF;
      default: return (kk * 9'h0A3) ^ 9'h155;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] xor_sum(input int pat);
    logic [WIDTH-1:0] s;
    s = '0;
    for (int k = 0; k < DEPTH; k++) s ^= stream_word(pat, k);
    return s;
  endfunction

  typedef struct {
    int               pat;
    bit               gaps;
    int               start_at;
    bit               corrupt;
    logic [WIDTH-1:0] exp_sum;
    bit               exp_err;
    logic [4:0]       exp_eaddr;
  } vec_t;
  vec_t vecs [6];

  task automatic run_vec(input int idx);
    vec_t v;
    int   i, gap, t;
    bit   pend, pulsed;
    v = vecs[idx]; i = 0; gap = 0; t = 0; pend = 0; pulsed = 0;
    for (int k = 0; k < DEPTH; k++) exp_words[k] = stream_word(v.pat, k);
    corrupt  = v.corrupt;
    wr_count = 0;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    check("start_busy", busy, 1);
    check("start_done_clr", done, 0);
    check("start_sum_clr", checksum, 0);
    check("start_hex", HEX0, HEX_WAIT);
    while (i < DEPTH && t < 3000) begin
      pat_in = exp_words[i];
      if (gap > 0) begin pat_valid = 1'b0; gap--; end
      else pat_valid = 1'b1;
      if (v.start_at == i && !pulsed && pat_ready) begin start = 1'b1; pulsed = 1; end
      pend = pat_valid && pat_ready;
      @(negedge clock); t++;
      start = 1'b0;
      if (pend) begin
        i++;
        if (v.gaps) gap = $urandom_range(0, 10);
      end
    end
    pat_valid = 1'b0;
    check("feed_complete", i, DEPTH);
    t = 0;
    while (!done && t < 200) begin @(negedge clock); t++; end
    check("done_set", done, 1);
    check("done_latency", cyc - last_wr_cyc, DONE_LAT);
    check("done_busy", busy, 0);
    check("done_hex", HEX0, HEX_DONE);
    check("checksum", checksum, v.exp_sum);
    check("error", error, v.exp_err);
    check("err_addr", err_addr, v.exp_eaddr);
    repeat (3) @(negedge clock);
    check("write_count", wr_count, DEPTH);
    check("idle_wren", ram_wren, 0);
    check("idle_ready", pat_ready, 0);
  endtask

  initial begin
    int t;
    vecs[0] = '{0, 1'b0, -1, 1'b0, xor_sum(0), 1'b0, 5'd0};
    vecs[1] = '{0, 1'b1, -1, 1'b0, xor_sum(0), 1'b0, 5'd0};
    vecs[2] = '{1, 1'b0, -1, 1'b0, 9'h000,     1'b0, 5'd0};
    vecs[3] = '{0, 1'b0,  3, 1'b0, xor_sum(0), 1'b0, 5'd0};
    vecs[4] = '{0, 1'b1, -1, 1'b1, xor_sum(0), VERIFY, VERIFY ? 5'd7 : 5'd0};
    vecs[5] = '{2, 1'b1, -1, 1'b0, xor_sum(2), 1'b0, 5'd0};

    #3 reset = 1'b0;
    #1;
    check("rst_ready", pat_ready, 0);
    check("rst_wren", ram_wren, 0);
    check("rst_addr", ram_address, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", checksum, 0);
    check("rst_hex", HEX0, HEX_IDLE);
    @(negedge clock); reset = 1'b1;
    @(negedge clock);
    check("idle_hex", HEX0, HEX_IDLE);

    for (int n = 0; n < 6; n++) run_vec(n);

    // abandon a pass with reset asserted during the WRITE of word 5
    for (int k = 0; k < DEPTH; k++) exp_words[k] = stream_word(0, k);
    corrupt = 1'b0; wr_count = 0;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0; pat_valid = 1'b1; pat_in = exp_words[0];
    t = 0;
    while (t < 200) begin
      @(negedge clock); t++;
      if (ram_wren && ram_address == 5'd5) break;
      if (pat_ready) pat_in = exp_words[wr_count];
    end
    check("reach_word5", int'(ram_wren && ram_address == 5'd5), 1);
    reset = 1'b0;
    #1;
    check("mid_rst_ready", pat_ready, 0);
    check("mid_rst_wren", ram_wren, 0);
    check("mid_rst_addr", ram_address, 0);
    check("mid_rst_data", ram_data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_error", error, 0);
    check("mid_rst_eaddr", err_addr, 0);
    check("mid_rst_sum", checksum, 0);
    check("mid_rst_hex", HEX0, HEX_IDLE);
    @(negedge clock); reset = 1'b1; pat_valid = 1'b0;
    @(negedge clock);

    run_vec(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
